dac_wave_sequencer: RTL

//  Digital stage directly upstream of the 4-bit analog DAC macro; produces its 4-bit input code.

---
 rtl/dac_wave_sequencer_pkg.sv | 19 +
 rtl/dac_wave_sequencer_if.sv | 34 +++
 rtl/dac_wave_sequencer_fifo.sv | 58 +++++
 rtl/dac_wave_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dac_wave_sequencer_pkg.sv
// Shared definitions for the DAC wave sequencer.
// Contents: DAC code width, the largest code value, the code type and the
// waveform mode encoding used on the mode input.
package dac_seq_pkg;

  localparam int CODE_W = 4;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_MAX = '1;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_RAMP = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_FIFO = 2'b11
  } mode_e;

endpackage

// File: rtl/dac_wave_sequencer_if.sv
// Host-side control and data bundle for the DAC wave sequencer.
// master: host (drives ena/mode/div and sample writes, observes the DAC side)
// slave : sequencer (consumes controls, drives code/strobe/status)
//   ena, mode, div            sample engine controls
//   wr_valid, wr_data, wr_ready  sample write handshake into the playback FIFO
//   code_out, code_strobe     registered DAC code and its update pulse
//   fifo_empty, underrun      playback status
interface dac_wave_sequencer_if #(
  parameter int DIV_W = 8
);
  import dac_seq_pkg::*;

  logic             ena;
  mode_e            mode;
  logic [DIV_W-1:0] div;
  logic             wr_valid;
  code_t            wr_data;
  logic             wr_ready;
  code_t            code_out;
  logic             code_strobe;
  logic             fifo_empty;
  logic             underrun;

  modport master (
    output ena, mode, div, wr_valid, wr_data,
    input  wr_ready, code_out, code_strobe, fifo_empty, underrun
  );

  modport slave (
    input  ena, mode, div, wr_valid, wr_data,
    output wr_ready, code_out, code_strobe, fifo_empty, underrun
  );

endinterface

// File: rtl/dac_wave_sequencer_fifo.sv
// dac_sample_fifo: synchronous FIFO buffering host samples for playback.
// Ports: clk, rst_n (async, active low), push/din write side, pop read side,
// head (oldest entry, valid when !empty), full, empty.
// A pop and a push in the same cycle both take effect, so a full FIFO can
// accept a write on a popping cycle.
module dac_sample_fifo
  import dac_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  code_t din,
  input  logic  pop,
  output code_t head,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_pop, do_push;
  code_t            mem [DEPTH];

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign head  = mem[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dac_wave_sequencer.sv
// dac_wave_sequencer: produces the 4-bit input code of the analog DAC.
// Ports: clk, rst_n (async, active low), bus (slave modport of
// dac_wave_sequencer_if carrying controls, sample writes and DAC outputs).
// A divider produces a tick every div+1 enabled cycles; each tick advances
// the code according to the mode sampled on that tick (hold, ramp, triangle,
// FIFO playback). Outputs are registered, one cycle after the tick.
module dac_wave_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  dac_wave_sequencer_if.slave bus
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic             dir_up_q, dir_up_d;
  code_t            code_q, code_d;
  logic             strobe_q, strobe_d;
  logic             underrun_q, underrun_d;

  logic  tick, dir_now, pop, push;
  code_t fifo_head;
  logic  fifo_full, fifo_empty;

  // ">=" lets a lowered div take effect on the next cycle instead of wrapping.
  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (bus.ena) begin
      if (cnt_q >= bus.div) tick = 1'b1;
      else                  cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Step rule uses the mode seen on this tick; entering TRIANGLE starts upward.
  always_comb begin
    mode_d     = mode_q;
    dir_up_d   = dir_up_q;
    code_d     = code_q;
    strobe_d   = tick;
    underrun_d = 1'b0;
    pop        = 1'b0;
    dir_now    = dir_up_q;
    if (tick) begin
      mode_d = bus.mode;
      case (bus.mode)
        MODE_RAMP: code_d = code_q + code_t'(1);
        MODE_TRI: begin
          dir_now = (mode_q != MODE_TRI) ? 1'b1 : dir_up_q;
          if (dir_now) begin
            if (code_q == CODE_MAX) begin
              dir_up_d = 1'b0;
              code_d   = CODE_MAX - code_t'(1);
            end else begin
              dir_up_d = 1'b1;
              code_d   = code_q + code_t'(1);
            end
          end else begin
            if (code_q == '0) begin
              dir_up_d = 1'b1;
              code_d   = code_t'(1);
            end else begin
              dir_up_d = 1'b0;
              code_d   = code_q - code_t'(1);
            end
          end
        end
        MODE_FIFO: begin
          if (fifo_empty) begin
            underrun_d = 1'b1;
          end else begin
            pop    = 1'b1;
            code_d = fifo_head;
          end
        end
        default: code_d = code_q;
      endcase
    end
  end

  // A popping tick frees a slot, so a full FIFO still accepts that cycle.
  assign bus.wr_ready = !fifo_full || pop;
  assign push         = bus.wr_valid && bus.wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      mode_q     <= MODE_HOLD;
      dir_up_q   <= 1'b1;
      code_q     <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      dir_up_q   <= dir_up_d;
      code_q     <= code_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  dac_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (bus.wr_data),
    .pop  (pop),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bus.code_out    = code_q;
  assign bus.code_strobe = strobe_q;
  assign bus.underrun    = underrun_q;
  assign bus.fifo_empty  = fifo_empty;

endmodule
